inst_issue_queue: RTL and testbench

- Circular instruction queue between the dual-fetch IF stage and the two DECODE units.
- Decouples fetch bandwidth (0–2 instructions per cycle) from launch bandwidth (0–2 instructions per cycle).
- Preserves program order, flushes on a taken branch, and back-pressures IF through a full flag.

---
 rtl/inst_issue_queue.sv | 129 ++++++++++++
 tb/tb_inst_issue_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/inst_issue_queue.sv
// Circular instruction queue between dual fetch and dual decode: in-order push/pop of up to 2 per cycle.
// Optional INSTBUF_BYPASS_EN: show inputs combinationally on the outputs while the queue is empty.
module inst_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stop,
  input  logic            branch_flag,
  input  logic [1:0]      issue,
  input  logic [XLEN-1:0] in1_inst,
  input  logic [XLEN-1:0] in1_pc,
  input  logic [XLEN-1:0] in1_npc,
  input  logic [XLEN-1:0] in2_inst,
  input  logic [XLEN-1:0] in2_pc,
  input  logic [XLEN-1:0] in2_npc,
  output logic [XLEN-1:0] out1_inst,
  output logic [XLEN-1:0] out1_pc,
  output logic [XLEN-1:0] out1_npc,
  output logic            sendout_flag1,
  output logic [XLEN-1:0] out2_inst,
  output logic [XLEN-1:0] out2_pc,
  output logic [XLEN-1:0] out2_npc,
  output logic            sendout_flag2,
  input  logic            launch_flag1,
  input  logic            launch_flag2,
  output logic            instbuf_full
);

  localparam logic [PTR_W:0] FULL_TH = (PTR_W+1)'(DEPTH - 2);

  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_npc  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [1:0]       push_n, pop_n;
  logic             we0, we1;
  logic [XLEN-1:0]  c0_inst, c0_pc, c0_npc;

  assign head_p1 = head_q + 1'b1;
  assign tail_p1 = tail_q + 1'b1;

  always_comb begin
    instbuf_full = (count_q > FULL_TH);

    // Compact valid inputs in program order: slot 0 takes in1 if valid, else in2.
    c0_inst = issue[0] ? in1_inst : in2_inst;
    c0_pc   = issue[0] ? in1_pc   : in2_pc;
    c0_npc  = issue[0] ? in1_npc  : in2_npc;
    push_n  = instbuf_full ? 2'd0 : ({1'b0, issue[0]} + {1'b0, issue[1]});

    sendout_flag1 = (count_q != '0);
    sendout_flag2 = (count_q >= (PTR_W+1)'(2));
    out1_inst = sendout_flag1 ? mem_inst[head_q]  : '0;
    out1_pc   = sendout_flag1 ? mem_pc[head_q]    : '0;
    out1_npc  = sendout_flag1 ? mem_npc[head_q]   : '0;
    out2_inst = sendout_flag2 ? mem_inst[head_p1] : '0;
    out2_pc   = sendout_flag2 ? mem_pc[head_p1]   : '0;
    out2_npc  = sendout_flag2 ? mem_npc[head_p1]  : '0;

`ifdef INSTBUF_BYPASS_EN
    // Empty queue: the incoming pair is presented directly. It is still written
    // below, and the head advances past whatever is launched this cycle.
    if (count_q == '0 && !branch_flag && !stop) begin
      sendout_flag1 = |issue;
      sendout_flag2 = &issue;
      out1_inst = sendout_flag1 ? c0_inst : '0;
      out1_pc   = sendout_flag1 ? c0_pc   : '0;
      out1_npc  = sendout_flag1 ? c0_npc  : '0;
      out2_inst = sendout_flag2 ? in2_inst : '0;
      out2_pc   = sendout_flag2 ? in2_pc   : '0;
      out2_npc  = sendout_flag2 ? in2_npc  : '0;
    end
`endif

    pop_n = {1'b0, launch_flag1 & sendout_flag1}
          + {1'b0, launch_flag1 & launch_flag2 & sendout_flag2};

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we0     = 1'b0;
    we1     = 1'b0;
    if (branch_flag) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (!stop) begin
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
      we0     = (push_n != 2'd0);
      we1     = (push_n == 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: reads are gated by the valid flags.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_inst[tail_q] <= c0_inst;
      mem_pc[tail_q]   <= c0_pc;
      mem_npc[tail_q]  <= c0_npc;
    end
    if (we1) begin
      mem_inst[tail_p1] <= in2_inst;
      mem_pc[tail_p1]   <= in2_pc;
      mem_npc[tail_p1]  <= in2_npc;
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue (default build): directed scenarios plus random traffic vs a queue model.
module tb_inst_issue_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } entry_t;

  logic clk = 1'b0;
  logic rst, stop, branch_flag, launch_flag1, launch_flag2;
  logic [1:0] issue;
  logic [XLEN-1:0] in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc;
  logic [XLEN-1:0] out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc;
  logic sendout_flag1, sendout_flag2, instbuf_full;

  int checks = 0;
  int errors = 0;
  entry_t model_q[$];

  always #5 clk = ~clk;

  inst_issue_queue #(.DEPTH(DEPTH), .PTR_W(3), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .stop(stop), .branch_flag(branch_flag), .issue(issue),
    .in1_inst(in1_inst), .in1_pc(in1_pc), .in1_npc(in1_npc),
    .in2_inst(in2_inst), .in2_pc(in2_pc), .in2_npc(in2_npc),
    .out1_inst(out1_inst), .out1_pc(out1_pc), .out1_npc(out1_npc), .sendout_flag1(sendout_flag1),
    .out2_inst(out2_inst), .out2_pc(out2_pc), .out2_npc(out2_npc), .sendout_flag2(sendout_flag2),
    .launch_flag1(launch_flag1), .launch_flag2(launch_flag2), .instbuf_full(instbuf_full)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    entry_t e1, e2;
    e1 = (model_q.size() >= 1) ? model_q[0] : '0;
    e2 = (model_q.size() >= 2) ? model_q[1] : '0;
    chk({tag, ".flag1"}, XLEN'(sendout_flag1), XLEN'(model_q.size() >= 1));
    chk({tag, ".flag2"}, XLEN'(sendout_flag2), XLEN'(model_q.size() >= 2));
    chk({tag, ".full"},  XLEN'(instbuf_full),  XLEN'(model_q.size() > DEPTH - 2));
    chk({tag, ".o1inst"}, out1_inst, e1.inst);
    chk({tag, ".o1pc"},   out1_pc,   e1.pc);
    chk({tag, ".o1npc"},  out1_npc,  e1.npc);
    chk({tag, ".o2inst"}, out2_inst, e2.inst);
    chk({tag, ".o2pc"},   out2_pc,   e2.pc);
    chk({tag, ".o2npc"},  out2_npc,  e2.npc);
  endtask

  // Applies one cycle of inputs (called at a negedge), advances the model, checks at next negedge.
  task automatic step(input string tag, input logic [1:0] iss, input logic [XLEN-1:0] p1,
                      input logic [XLEN-1:0] p2, input logic l1, input logic l2,
                      input logic st, input logic br);
    int npop;
    bit full;
    issue = iss; launch_flag1 = l1; launch_flag2 = l2; stop = st; branch_flag = br;
    in1_inst = $urandom; in1_pc = p1; in1_npc = p1 + 4;
    in2_inst = $urandom; in2_pc = p2; in2_npc = p2 + 4;
    if (br) begin
      model_q.delete();
    end else if (!st) begin
      full = model_q.size() > DEPTH - 2;
      npop = 0;
      if (l1 && model_q.size() >= 1) npop = 1;
      if (l1 && l2 && model_q.size() >= 2) npop = 2;
      repeat (npop) void'(model_q.pop_front());
      if (!full) begin
        if (iss[0]) model_q.push_back('{in1_inst, in1_pc, in1_npc});
        if (iss[1]) model_q.push_back('{in2_inst, in2_pc, in2_npc});
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [XLEN-1:0] h1, h2;
    rst = 1'b0; stop = 1'b0; branch_flag = 1'b0; issue = 2'b00;
    launch_flag1 = 1'b0; launch_flag2 = 1'b0;
    in1_inst = '0; in1_pc = '0; in1_npc = '0; in2_inst = '0; in2_pc = '0; in2_npc = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // First pair, then fill toward full; pushes while full are dropped whole.
    step("pair0", 2'b11, 32'h00, 32'h04, 0, 0, 0, 0);
    chk("pair0.pc2", out2_pc, 32'h04);
    step("fill1", 2'b11, 32'h08, 32'h0C, 0, 0, 0, 0);
    step("fill2", 2'b11, 32'h10, 32'h14, 0, 0, 0, 0);
    chk("fill2.notfull", XLEN'(instbuf_full), 0);
    step("fill3", 2'b11, 32'h18, 32'h1C, 0, 0, 0, 0);
    chk("fill3.full", XLEN'(instbuf_full), 1);
    step("drop",  2'b11, 32'h20, 32'h24, 0, 0, 0, 0);
    step("drop1", 2'b01, 32'h28, 32'h2C, 0, 0, 0, 0);

    // Dual launch with only three entries, then launch_flag2 alone.
    step("flush0", 2'b00, 0, 0, 0, 0, 0, 1);
    step("p3a", 2'b11, 32'h10, 32'h14, 0, 0, 0, 0);
    step("p3b", 2'b01, 32'h18, 32'h1C, 0, 0, 0, 0);
    step("l12", 2'b00, 0, 0, 1, 1, 0, 0);
    chk("l12.pc1", out1_pc, 32'h18);
    step("l2only", 2'b00, 0, 0, 0, 1, 0, 0);
    chk("l2only.pc1", out1_pc, 32'h18);
    step("iss10", 2'b10, 32'h50, 32'h54, 0, 0, 0, 0);
    chk("iss10.pc2", out2_pc, 32'h54);

    // Flush with a concurrent push.
    step("p4a", 2'b11, 32'h60, 32'h64, 0, 0, 0, 0);
    step("br_push", 2'b11, 32'h68, 32'h6C, 1, 1, 0, 1);

    // Walk head to DEPTH-1 with two entries live, then freeze.
    step("w0", 2'b11, 32'h100, 32'h104, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("w", 2'b11, 32'h108 + 8 * i, 32'h10C + 8 * i, 1, 1, 0, 0);
    step("w_last", 2'b01, 32'h120, 32'h0, 1, 0, 0, 0);
    chk("wrap.pc1", out1_pc, 32'h11C);
    chk("wrap.pc2", out2_pc, 32'h120);
    h1 = out1_pc; h2 = out2_pc;
    for (int i = 0; i < 3; i++)
      step("stop", 2'b11, $urandom, $urandom, 1, 1, 1, 0);
    chk("stop.pc1", out1_pc, h1);
    chk("stop.pc2", out2_pc, h2);

    // Random traffic.
    for (int i = 0; i < 500; i++)
      step("rnd", 2'($urandom_range(0, 3)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));

    // Asynchronous reset at five entries, asserted between edges.
    step("ar0", 2'b00, 0, 0, 0, 0, 0, 1);
    step("ar1", 2'b11, 32'h200, 32'h204, 0, 0, 0, 0);
    step("ar2", 2'b11, 32'h208, 32'h20C, 0, 0, 0, 0);
    step("ar3", 2'b01, 32'h210, 32'h214, 0, 0, 0, 0);
    chk("ar3.pc1", out1_pc, 32'h200);
    issue = 2'b00;
    #2 rst = 1'b0;
    model_q.delete();
    #1 check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 2'b11, 32'h300, 32'h304, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
